// File: rtl/fp_normalize_round_32bit.sv
// Three-stage normalise + round-to-nearest-even back end for the FP32 adder sum.
// Optional denormal results: define FP_NORM_DENORM_EN (default flushes underflow to signed zero).
module fp_normalize_round_32bit #(
    parameter int unsigned BIAS    = 127,
    parameter int unsigned EXP_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [8:0]  in_exp,
    input  logic [26:0] in_mant,
    input  logic        in_sticky,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_f,
    output logic        out_ovf,
    output logic        out_unf
);
    localparam int unsigned EW  = 10;
    localparam int unsigned MW  = 26;
    localparam int unsigned LZW = 5;
    localparam int          EMIN = 1 - int'(BIAS);
    localparam logic signed [EW-1:0] EMIN_CODE = EW'(EMIN + int'(BIAS));
    localparam logic [EW-1:0]        EXP_MAX_C = EW'(EXP_MAX);

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic                 s1_valid, s2_valid;
    logic                 s1_sign, s1_sticky, s1_zero, s1_inf;
    logic signed [EW-1:0] s1_exp;
    logic [MW-1:0]        s1_mant;
    logic [LZW-1:0]       s1_lz;

    logic                 s2_sign, s2_sticky, s2_zero, s2_unf, s2_den, s2_inf;
    logic [8:0]           s2_exp;
    logic [MW-1:0]        s2_mant;

    // leading-zero count of the hidden/fraction/guard/round field
    logic [LZW-1:0] lz_c;
    always_comb begin
        lz_c = LZW'(MW);
        for (int i = 0; i < int'(MW); i++) begin
            if (in_mant[i]) lz_c = LZW'(int'(MW) - 1 - i);
        end
    end

    // S2 normalise: shift to target exponent, or handle underflow
    logic signed [EW-1:0] e_c;
    logic [MW-1:0]        s2_mant_c;
    logic [8:0]           s2_exp_c;
    logic                 s2_sticky_c, s2_zero_c, s2_unf_c, s2_den_c;
    always_comb begin
        e_c         = s1_exp - EW'(s1_lz);
        s2_mant_c   = s1_mant << s1_lz;
        s2_exp_c    = e_c[8:0];
        s2_sticky_c = s1_sticky;
        s2_zero_c   = 1'b0;
        s2_unf_c    = 1'b0;
        s2_den_c    = 1'b0;
        if (s1_zero) begin
            s2_zero_c = 1'b1;
            s2_mant_c = '0;
            s2_exp_c  = '0;
        end else if (e_c < EMIN_CODE) begin
`ifdef FP_NORM_DENORM_EN
            s2_den_c = 1'b1;
            s2_exp_c = '0;
            if (s1_exp >= EMIN_CODE) begin
                s2_mant_c = s1_mant << LZW'(s1_exp - EMIN_CODE);
            end else begin
                // exponent 0 sits one binade below the denormal scale
                s2_mant_c   = s1_mant >> 1;
                s2_sticky_c = s1_sticky | s1_mant[0];
            end
`else
            s2_zero_c = 1'b1;
            s2_unf_c  = 1'b1;
            s2_mant_c = '0;
            s2_exp_c  = '0;
`endif
        end
    end

    // S3 round to nearest even and pack
    logic          g_c, rs_c, inc_c;
    logic [24:0]   sig_c;
    logic [EW-1:0] exp_f_c;
    logic [31:0]   f_c;
    logic          ovf_c, unf_c;
    always_comb begin
        g_c     = s2_mant[1];
        rs_c    = s2_mant[0] | s2_sticky;
        inc_c   = g_c & (rs_c | s2_mant[2]);
        sig_c   = {1'b0, s2_mant[25:2]} + 25'(inc_c);
        // a denormal rounding into the hidden bit becomes exponent 1
        exp_f_c = EW'(s2_exp) + EW'(s2_den ? sig_c[23] : sig_c[24]);
        f_c     = {s2_sign, exp_f_c[7:0], sig_c[22:0]};
        ovf_c   = 1'b0;
        unf_c   = s2_den & (g_c | rs_c);
        if (s2_inf || (exp_f_c >= EXP_MAX_C)) begin
            f_c   = {s2_sign, 8'hFF, 23'h0};
            ovf_c = 1'b1;
            unf_c = 1'b0;
        end else if (s2_zero) begin
            f_c   = {s2_sign, 31'h0};
            unf_c = s2_unf;
        end
    end

    // valid bits and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_f     <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_f   <= f_c;
                out_ovf <= ovf_c;
                out_unf <= unf_c;
            end
        end
    end

    // pipeline payload, advanced in lock-step with the valid bits
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_sign <= in_sign;
            s1_inf  <= (EW'(in_exp) >= EXP_MAX_C);
            s1_zero <= (in_mant == '0);
            if (in_mant[26]) begin
                s1_mant   <= in_mant[26:1];
                s1_sticky <= in_sticky | in_mant[0];
                s1_exp    <= EW'(in_exp) + EW'(1);
                s1_lz     <= '0;
            end else begin
                s1_mant   <= in_mant[25:0];
                s1_sticky <= in_sticky;
                s1_exp    <= EW'(in_exp);
                s1_lz     <= lz_c;
            end

            s2_sign   <= s1_sign;
            s2_inf    <= s1_inf;
            s2_zero   <= s2_zero_c;
            s2_unf    <= s2_unf_c;
            s2_den    <= s2_den_c;
            s2_exp    <= s2_exp_c;
            s2_mant   <= s2_mant_c;
            s2_sticky <= s2_sticky_c;
        end
    end

endmodule

// File: tb/tb_fp_normalize_round_32bit.sv
// Bench for fp_normalize_round_32bit: directed vectors, backpressure/reset sequences, random vs. value model.
module tb_fp_normalize_round_32bit;

    logic        clk, rst;
    logic        in_valid, in_ready, in_sign, in_sticky;
    logic [8:0]  in_exp;
    logic [26:0] in_mant;
    logic        out_valid, out_ready, out_ovf, out_unf;
    logic [31:0] out_f;

    fp_normalize_round_32bit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        s;
        logic [8:0]  e;
        logic [26:0] m;
        logic        st;
        logic [31:0] f;
        logic        ovf;
        logic        unf;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          n_out  = 0;
    logic        last_acc;
    logic        bp_rand;
    logic [33:0] cur_exp;
    logic [33:0] expq[$];
    vec_t        tbl[$];

    // Reference: value = mant * 2^(exp-152); sticky is an infinitesimal below the LSB.
    function automatic logic [33:0] model(input logic s, input logic [8:0] e,
                                          input logic [26:0] m, input logic st);
        int     p, ee, sh;
        longint x, sig, rem, half;
        if (e >= 9'd255) return {s, 8'hFF, 23'h0, 2'b10};
        if (m == '0)     return {s, 31'h0, 2'b00};
        p = 0;
        for (int i = 0; i < 27; i++) if (m[i]) p = i;
        ee = int'(e) + p - 25;
        x  = (longint'(m) << 2) | longint'(st);
        if (ee >= 1) begin
            if (p <= 23) begin
                sig = longint'(m) << (23 - p);
            end else begin
                sh   = p - 21;
                sig  = x >> sh;
                rem  = x & ((longint'(1) << sh) - 1);
                half = longint'(1) << (sh - 1);
                if (rem > half || (rem == half && sig[0])) sig = sig + 1;
                if (sig == (longint'(1) << 24)) begin
                    sig = sig >> 1;
                    ee  = ee + 1;
                end
            end
            if (ee >= 255) return {s, 8'hFF, 23'h0, 2'b10};
            return {s, 8'(ee), 23'(sig), 2'b00};
        end
`ifdef FP_NORM_DENORM_EN
        begin
            logic inexact;
            if (int'(e) >= 3) begin
                sig     = longint'(m) << (int'(e) - 3);
                inexact = st;
            end else begin
                sh      = 5 - int'(e);
                sig     = x >> sh;
                rem     = x & ((longint'(1) << sh) - 1);
                half    = longint'(1) << (sh - 1);
                inexact = (rem != 0);
                if (rem > half || (rem == half && sig[0])) sig = sig + 1;
            end
            return {s, 31'(sig), 1'b0, inexact};
        end
`else
        return {s, 31'h0, 2'b01};
`endif
    endfunction

    function automatic vec_t mk(input logic s, input logic [8:0] e, input logic [26:0] m,
                                input logic st, input logic [31:0] f, input logic ovf, input logic unf);
        vec_t v;
        v.s = s; v.e = e; v.m = m; v.st = st; v.f = f; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    function automatic logic [8:0] rand_exp();
        case ($urandom_range(0, 3))
            0:       return 9'($urandom_range(0, 30));
            1:       return 9'($urandom_range(100, 160));
            2:       return 9'($urandom_range(240, 260));
            default: return 9'($urandom_range(0, 511));
        endcase
    endfunction

    function automatic logic [26:0] rand_mant();
        logic [26:0] m;
        m = 27'($urandom);
        case ($urandom_range(0, 3))
            0:       ;
            1:       m = {2'b01, m[24:0]};
            2:       m = m >> $urandom_range(0, 27);
            default: m = {2'b01, m[24:2], 2'b10};
        endcase
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // scoreboard: consume outputs, record accepted inputs (sampled mid-cycle)
    task automatic monitor();
        logic [33:0] got, want;
        last_acc = 1'b0;
        if (rst) return;
        if (out_valid && out_ready) begin
            got = {out_f, out_ovf, out_unf};
            checks++;
            n_out++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got f=%08h ovf=%0b unf=%0b, expected no output",
                         out_f, out_ovf, out_unf);
            end else begin
                want = expq.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL result_%0d: got f=%08h ovf=%0b unf=%0b, expected f=%08h ovf=%0b unf=%0b",
                             n_out, got[33:2], got[1], got[0], want[33:2], want[1], want[0]);
                end
            end
        end
        if (in_valid && in_ready) begin
            expq.push_back(cur_exp);
            last_acc = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (bp_rand) out_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic drive(input logic s, input logic [8:0] e, input logic [26:0] m,
                         input logic st, input logic [33:0] expv);
        in_sign = s; in_exp = e; in_mant = m; in_sticky = st;
        cur_exp = expv;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic s, input logic [8:0] e, input logic [26:0] m,
                        input logic st, input logic [33:0] expv);
        drive(s, e, m, st, expv);
        for (int k = 0; k < 200; k++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready stuck low, expected acceptance within 200 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && expq.size() != 0; k++) tick();
        chk("drain_empty", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        int       idx, n_before;
        vec_t     v;
        vec_t     bp[5];

        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; in_sticky = 1'b0;
        out_ready = 1'b1; bp_rand = 1'b0; cur_exp = '0; last_acc = 1'b0;

        tbl.push_back(mk(0, 9'd127, 27'h4000000, 0, 32'h40000000, 0, 0));
        tbl.push_back(mk(0, 9'd130, 27'h0800000, 0, 32'h40000000, 0, 0));
        tbl.push_back(mk(0, 9'd127, 27'h2000002, 0, 32'h3F800000, 0, 0));
        tbl.push_back(mk(0, 9'd127, 27'h2000006, 0, 32'h3F800002, 0, 0));
        tbl.push_back(mk(0, 9'd127, 27'h2000002, 1, 32'h3F800001, 0, 0));
        tbl.push_back(mk(0, 9'd254, 27'h4000000, 0, 32'h7F800000, 1, 0));
        tbl.push_back(mk(1, 9'd100, 27'h0000000, 0, 32'h80000000, 0, 0));
        tbl.push_back(mk(1, 9'd300, 27'h2000000, 0, 32'hFF800000, 1, 0));
        tbl.push_back(mk(0, 9'd127, 27'h3FFFFFE, 0, 32'h40000000, 0, 0));
        tbl.push_back(mk(1, 9'd127, 27'h2000003, 0, 32'hBF800001, 0, 0));
        tbl.push_back(mk(0, 9'd254, 27'h3FFFFFE, 0, 32'h7F800000, 1, 0));
        tbl.push_back(mk(0, 9'd2,   27'h1000000, 0, 32'h00800000, 0, 0));
`ifdef FP_NORM_DENORM_EN
        tbl.push_back(mk(0, 9'd1,   27'h0800000, 0, 32'h00200000, 0, 0));
        tbl.push_back(mk(0, 9'd0,   27'h2000000, 0, 32'h00400000, 0, 0));
`else
        tbl.push_back(mk(0, 9'd1,   27'h0800000, 0, 32'h00000000, 0, 1));
        tbl.push_back(mk(1, 9'd0,   27'h2000000, 0, 32'h80000000, 0, 1));
`endif

        // reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_f",     64'(out_f),     64'd0);
        chk("reset_flags",     64'({out_ovf, out_unf}), 64'd0);
        chk("reset_in_ready",  64'(in_ready),  64'd1);

        // latency: output appears in the third cycle after acceptance
        send(1'b0, 9'd127, 27'h4000000, 1'b0, {32'h40000000, 2'b00});
        @(negedge clk); chk("latency_c1", 64'(out_valid), 64'd0); @(posedge clk); #1;
        @(negedge clk); chk("latency_c2", 64'(out_valid), 64'd0); @(posedge clk); #1;
        tick();
        chk("latency_c3_valid", 64'(n_out), 64'd1);
        drain();

        // directed table, streamed back to back
        foreach (tbl[i]) begin
            v = tbl[i];
            send(v.s, v.e, v.m, v.st, {v.f, v.ovf, v.unf});
        end
        drain();

        // backpressure: five inputs against a stalled consumer
        for (int i = 0; i < 5; i++) bp[i] = mk(0, 9'(120 + i), 27'h2000000 | 27'(i * 4), 0, '0, 0, 0);
        n_before = n_out;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            drive(bp[idx].s, bp[idx].e, bp[idx].m, bp[idx].st, model(bp[idx].s, bp[idx].e, bp[idx].m, bp[idx].st));
            tick();
            if (last_acc) idx++;
            if (c >= 4) chk("bp_hold_out_f", 64'(out_f), 64'(model(bp[0].s, bp[0].e, bp[0].m, bp[0].st) >> 2));
        end
        chk("bp_accepted",  64'(idx),       64'd3);
        chk("bp_in_ready",  64'(in_ready),  64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 50 && idx < 5; c++) begin
            drive(bp[idx].s, bp[idx].e, bp[idx].m, bp[idx].st, model(bp[idx].s, bp[idx].e, bp[idx].m, bp[idx].st));
            tick();
            if (last_acc) idx++;
        end
        in_valid = 1'b0;
        drain();
        chk("bp_delivered", 64'(n_out - n_before), 64'd5);

        // reset with results in flight
        for (int c = 0; c < 3; c++) begin
            drive(0, 9'd127, 27'h2000000 | 27'(c * 8), 0, model(0, 9'd127, 27'h2000000 | 27'(c * 8), 0));
            tick();
        end
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        rst = 1'b0;
        expq.delete();
        n_before = n_out;
        repeat (10) tick();
        chk("rst_no_output", 64'(n_out - n_before), 64'd0);

        // randomized traffic with random consumer stalls
        bp_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic        rs, rst_b;
            logic [8:0]  re;
            logic [26:0] rm;
            rs    = 1'($urandom);
            re    = rand_exp();
            rm    = rand_mant();
            rst_b = ($urandom_range(0, 3) == 0);
            send(rs, re, rm, rst_b, model(rs, re, rm, rst_b));
            if ($urandom_range(0, 3) == 0) tick();
        end
        bp_rand = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
